// File: rtl/replica_exchange_ctrl.sv
// Sequencer for a replica-exchange array: OPT sweeps, alternating-parity EXCH swaps, SHIFT readout.
// command is flat, element r at [2r+1:2r]; encoding THR=0, PREV=1, FOLW=2.
module replica_exchange_ctrl #(
    parameter int replica_num = 32,
    parameter int opt_cycles  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [15:0]              iter_num,
    input  logic                     shift_req,
    input  logic                     abort,
    input  logic [replica_num-2:0]   pair_accept,
    output logic                     busy,
    output logic                     done,
    output logic                     exchange_valid,
    output logic                     metropolis_test,
    output logic                     shift_distance,
    output logic [2*replica_num-1:0] command
);

    localparam int OPT_W = (opt_cycles > 1) ? $clog2(opt_cycles) : 1;
    localparam int SHF_W = $clog2(replica_num);
    localparam logic [OPT_W-1:0] OPT_LAST = OPT_W'(opt_cycles - 1);
    localparam logic [SHF_W-1:0] SHF_LAST = SHF_W'(replica_num - 1);
    localparam logic [1:0] CMD_THR  = 2'd0;
    localparam logic [1:0] CMD_PREV = 2'd1;
    localparam logic [1:0] CMD_FOLW = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_OPT, S_EXCH, S_SHIFT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [OPT_W-1:0]         opt_cnt_q, opt_cnt_d;
    logic [SHF_W-1:0]         shf_cnt_q, shf_cnt_d;
    logic [15:0]              sweep_q, sweep_d;
    logic [15:0]              iter_q, iter_d;
    logic [16:0]              sweep_inc;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     ev_q, ev_d, mt_q, mt_d, sd_q, sd_d;
    logic [2*replica_num-1:0] cmd_q, cmd_d;

    // 17-bit increment so the compare against iter_num=65535 cannot wrap
    assign sweep_inc = {1'b0, sweep_q} + 17'd1;

    always_comb begin
        state_d   = state_q;
        opt_cnt_d = opt_cnt_q;
        shf_cnt_d = shf_cnt_q;
        sweep_d   = sweep_q;
        iter_d    = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (iter_num != 16'd0) begin
                        state_d   = S_OPT;
                        opt_cnt_d = '0;
                        sweep_d   = '0;
                        iter_d    = iter_num;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (shift_req) begin
                    state_d   = S_SHIFT;
                    shf_cnt_d = '0;
                end
            end
            S_OPT: begin
                if (opt_cnt_q == OPT_LAST) state_d = S_EXCH;
                else                       opt_cnt_d = opt_cnt_q + OPT_W'(1);
            end
            S_EXCH: begin
                sweep_d = sweep_inc[15:0];
                if (sweep_inc < {1'b0, iter_q}) begin
                    state_d   = S_OPT;
                    opt_cnt_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                if (shf_cnt_q == SHF_LAST) state_d = S_IDLE;
                else                       shf_cnt_d = shf_cnt_q + SHF_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Outputs are decoded from the next state so they register alongside it;
    // pair_accept is therefore sampled on the edge that enters EXCH.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ev_d   = (state_d == S_OPT) || (state_d == S_EXCH);
        mt_d   = (state_d == S_OPT);
        sd_d   = (state_d == S_SHIFT);
        cmd_d  = {replica_num{CMD_THR}};
        if (state_d == S_EXCH) begin
            for (int i = 0; i < replica_num - 1; i++) begin
                if ((i[0] == sweep_q[0]) && pair_accept[i]) begin
                    cmd_d[2*i +: 2]     = CMD_FOLW;
                    cmd_d[2*i + 2 +: 2] = CMD_PREV;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opt_cnt_q <= '0;
            shf_cnt_q <= '0;
            sweep_q   <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ev_q      <= 1'b0;
            mt_q      <= 1'b0;
            sd_q      <= 1'b0;
            cmd_q     <= {replica_num{CMD_THR}};
        end else begin
            state_q   <= state_d;
            opt_cnt_q <= opt_cnt_d;
            shf_cnt_q <= shf_cnt_d;
            sweep_q   <= sweep_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ev_q      <= ev_d;
            mt_q      <= mt_d;
            sd_q      <= sd_d;
            cmd_q     <= cmd_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign exchange_valid  = ev_q;
    assign metropolis_test = mt_q;
    assign shift_distance  = sd_q;
    assign command         = cmd_q;

endmodule

// File: tb/tb_replica_exchange_ctrl.sv
// Bench for replica_exchange_ctrl: expected per-cycle output traces are built from the
// run/shift/abort rules, then compared cycle by cycle against the DUT.
module tb_replica_exchange_ctrl;

    localparam int R  = 4;
    localparam int OC = 3;
    localparam logic [1:0] THR = 2'd0, PREV = 2'd1, FOLW = 2'd2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [15:0]    iter_num = 16'd0;
    logic           shift_req = 1'b0;
    logic           abort = 1'b0;
    logic [R-2:0]   pair_accept = '0;
    logic           busy, done, exchange_valid, metropolis_test, shift_distance;
    logic [2*R-1:0] command;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    logic [2*R-1:0] exch_seen[$];

    replica_exchange_ctrl #(.replica_num(R), .opt_cycles(OC)) dut (
        .clk(clk), .reset(reset), .start(start), .iter_num(iter_num),
        .shift_req(shift_req), .abort(abort), .pair_accept(pair_accept),
        .busy(busy), .done(done), .exchange_valid(exchange_valid),
        .metropolis_test(metropolis_test), .shift_distance(shift_distance),
        .command(command)
    );

    always #5 clk = ~clk;

    // {busy, done, exchange_valid, metropolis_test, shift_distance, command}
    function automatic logic [12:0] w(bit b, bit d, bit ev, bit mt, bit sd, logic [7:0] c);
        return {b, d, ev, mt, sd, c};
    endfunction

    // Eligible pairs have i mod 2 == parity; an accepted one swaps left=FOLW, right=PREV.
    function automatic logic [7:0] exch_cmd(int parity, logic [R-2:0] acc);
        logic [7:0] c;
        c = {R{THR}};
        for (int i = 0; i < R - 1; i++)
            if ((i % 2) == parity && acc[i]) begin
                c[2*i +: 2]       = FOLW;
                c[2*(i+1) +: 2]   = PREV;
            end
        return c;
    endfunction

    function automatic logic [12:0] obs();
        return {busy, done, exchange_valid, metropolis_test, shift_distance, command};
    endfunction

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic chk_val(input string tag, input int o, input int exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
        end
    endtask

    // One run from IDLE. abort_at >= 0 raises abort so that output index abort_at is IDLE.
    // sr_hold = number of edges (starting with the start edge) on which shift_req is high.
    task automatic run(input int n, input logic [R-2:0] acc_fixed, input bit rand_acc,
                       input int abort_at, input int sr_hold);
        logic [12:0]  exp[$];
        logic [R-2:0] accs[$];
        int total;
        total = (n == 0) ? 2 : n * (OC + 1) + 2;
        for (int k = 0; k < total + 3; k++)
            accs.push_back(rand_acc ? R'($urandom) : acc_fixed);
        for (int s = 0; s < n; s++) begin
            for (int o = 0; o < OC; o++) exp.push_back(w(1, 0, 1, 1, 0, 8'h00));
            exp.push_back(w(1, 0, 1, 0, 0, exch_cmd(s % 2, accs[exp.size()])));
        end
        exp.push_back(w(1, 1, 0, 0, 0, 8'h00));
        exp.push_back(w(0, 0, 0, 0, 0, 8'h00));
        if (abort_at >= 0) begin
            while (exp.size() > abort_at) void'(exp.pop_back());
            exp.push_back(w(0, 0, 0, 0, 0, 8'h00));
            exp.push_back(w(0, 0, 0, 0, 0, 8'h00));
        end
        iter_num    = 16'(n);
        pair_accept = accs[0];
        start       = 1'b1;
        shift_req   = (sr_hold > 0);
        abort       = (abort_at == 0);
        busy_cnt    = 0;
        exch_seen.delete();
        for (int k = 0; k < exp.size(); k++) begin
            @(posedge clk); #1;
            chk($sformatf("run_n%0d_ab%0d_c%0d", n, abort_at, k), exp[k]);
            if (busy) busy_cnt++;
            if (exchange_valid && !metropolis_test) exch_seen.push_back(command);
            start       = 1'b0;
            abort       = (k + 1 == abort_at);
            shift_req   = (k + 1 < sr_hold);
            pair_accept = accs[k + 1];
        end
        abort     = 1'b0;
        shift_req = 1'b0;
    endtask

    task automatic do_shift();
        shift_req = 1'b1;
        for (int k = 0; k <= R; k++) begin
            @(posedge clk); #1;
            chk($sformatf("shift_c%0d", k),
                (k < R) ? w(1, 0, 0, 0, 1, 8'h00) : w(0, 0, 0, 0, 0, 8'h00));
            shift_req = 1'b0;
        end
    endtask

    initial begin
        int n;
        #1;
        chk("reset_held", w(0, 0, 0, 0, 0, 8'h00));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", w(0, 0, 0, 0, 0, 8'h00));

        // Basic two-sweep run with every pair accepted
        run(2, 3'b111, 0, -1, 0);
        chk_val("basic_busy_cycles", busy_cnt, 9);
        chk_val("basic_exch_count", exch_seen.size(), 2);
        if (exch_seen.size() == 2) begin
            chk_val("basic_exch0", int'(exch_seen[0]), 8'h66);
            chk_val("basic_exch1", int'(exch_seen[1]), 8'h18);
        end

        // Rejected pair
        run(1, 3'b001, 0, -1, 0);
        if (exch_seen.size() == 1) chk_val("reject_exch", int'(exch_seen[0]), 8'h06);
        else chk_val("reject_exch_count", exch_seen.size(), 1);

        // Ineligible-only accept bit is ignored on an even sweep
        run(1, 3'b010, 0, -1, 0);

        // Zero iterations
        run(0, 3'b111, 0, -1, 0);
        chk_val("zero_iter_no_exch", exch_seen.size(), 0);

        // Readout
        do_shift();

        // start and shift_req together, shift_req held into OPT
        run(2, 3'b101, 0, -1, 3);

        // Abort in 2nd OPT cycle, and abort outranking start
        run(2, 3'b111, 0, 2, 0);
        run(2, 3'b111, 0, 0, 0);

        // Randomized runs with pair_accept changing every cycle
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 5);
            run(n, '0, 1, -1, 0);
        end
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 4);
            run(n, '0, 1, $urandom_range(1, n * (OC + 1)), 0);
        end

        // Reset asserted mid-EXCH
        iter_num = 16'd1; pair_accept = 3'b111; start = 1'b1;
        for (int k = 0; k < OC; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_opt_c%0d", k), w(1, 0, 1, 1, 0, 8'h00));
            start = 1'b0;
        end
        @(posedge clk); #1;
        chk("rst_exch", w(1, 0, 1, 0, 0, exch_cmd(0, 3'b111)));
        #2 reset = 1'b0;
        #1 chk("rst_immediate", w(0, 0, 0, 0, 0, 8'h00));
        @(posedge clk); #1;
        chk("rst_held_no_done", w(0, 0, 0, 0, 0, 8'h00));
        reset = 1'b1;
        run(2, 3'b011, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
